// File: rtl/paddle_ctrl.sv
// Paddle position controller: accumulates per-player press pulses during a frame
// and applies them once per frame so the renderer never sees a mid-frame move.
module paddle_ctrl #(
  parameter int SCREEN_H = 480,
  parameter int PADDLE_H = 64,
  parameter int STEP     = 8,
  parameter int Y_W      = 10,
  parameter int PEND_W   = 4,
  parameter int INIT_Y   = 208
) (
  input  logic           pixel_clk,
  input  logic           reset,
  input  logic           frame_tick,
  input  logic           enable,
  input  logic           center_req,
  input  logic           PlayerA_up_i,
  input  logic           PlayerA_down_i,
  input  logic           PlayerB_up_i,
  input  logic           PlayerB_down_i,
  output logic [Y_W-1:0] paddleA_y,
  output logic [Y_W-1:0] paddleB_y,
  output logic           paddle_update,
  output logic           busy
);

  localparam int SW = Y_W + PEND_W + 2;
  localparam logic signed [PEND_W-1:0] PMAX_P = PEND_W'(2 ** (PEND_W - 1) - 1);
  localparam logic signed [PEND_W-1:0] PMIN_P = -PMAX_P;
  localparam logic signed [SW-1:0]     STEP_S = SW'(STEP);
  localparam logic signed [SW-1:0]     YMAX_S = SW'(SCREEN_H - PADDLE_H);
  localparam logic [Y_W-1:0]           INIT_V = Y_W'(INIT_Y);

  typedef enum logic [1:0] {S_IDLE, S_SNAP, S_WRITE} state_t;

  state_t                    r_state;
  logic signed [PEND_W-1:0]  r_pendA, r_pendB, r_snapA, r_snapB;
  logic signed [SW-1:0]      r_sumA, r_sumB;
  logic [Y_W-1:0]            r_yA, r_yB;
  logic                      r_center, r_centerSnap, r_update, r_busy;

  logic                      w_take;
  logic signed [PEND_W-1:0]  w_pendANext, w_pendBNext;
  logic signed [SW-1:0]      w_sumA, w_sumB;
  logic [Y_W-1:0]            w_clampA, w_clampB;

  function automatic logic signed [PEND_W-1:0] satStep(input logic signed [PEND_W-1:0] p,
                                                       input logic up, input logic dn);
    satStep = p;
    if (dn && !up && p != PMAX_P)      satStep = p + PEND_W'(1);
    else if (up && !dn && p != PMIN_P) satStep = p - PEND_W'(1);
  endfunction

  function automatic logic [Y_W-1:0] clampY(input logic signed [SW-1:0] s);
    if (s < 0)           clampY = '0;
    else if (s > YMAX_S) clampY = YMAX_S[Y_W-1:0];
    else                 clampY = s[Y_W-1:0];
  endfunction

  // A pulse coincident with an accepted tick lands in the freshly cleared counter.
  always_comb begin
    w_take      = (r_state == S_IDLE) && frame_tick;
    w_pendANext = '0;
    w_pendBNext = '0;
    if (enable) begin
      w_pendANext = satStep(w_take ? '0 : r_pendA, PlayerA_up_i, PlayerA_down_i);
      w_pendBNext = satStep(w_take ? '0 : r_pendB, PlayerB_up_i, PlayerB_down_i);
    end
    w_sumA   = $signed(SW'(r_yA)) + $signed({{(SW-PEND_W){r_snapA[PEND_W-1]}}, r_snapA}) * STEP_S;
    w_sumB   = $signed(SW'(r_yB)) + $signed({{(SW-PEND_W){r_snapB[PEND_W-1]}}, r_snapB}) * STEP_S;
    w_clampA = clampY(r_sumA);
    w_clampB = clampY(r_sumB);
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pendA      <= '0;
      r_pendB      <= '0;
      r_snapA      <= '0;
      r_snapB      <= '0;
      r_sumA       <= '0;
      r_sumB       <= '0;
      r_yA         <= INIT_V;
      r_yB         <= INIT_V;
      r_center     <= 1'b0;
      r_centerSnap <= 1'b0;
      r_update     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_pendA  <= w_pendANext;
      r_pendB  <= w_pendBNext;
      r_update <= 1'b0;
      // A new request wins over the clear so a late request still applies next frame.
      if (center_req)
        r_center <= 1'b1;
      else if (r_state == S_WRITE && r_centerSnap)
        r_center <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (frame_tick) begin
            r_snapA      <= r_pendA;
            r_snapB      <= r_pendB;
            r_centerSnap <= r_center;
            r_busy       <= 1'b1;
            r_state      <= S_SNAP;
          end
        end
        S_SNAP: begin
          r_sumA  <= w_sumA;
          r_sumB  <= w_sumB;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          if (r_centerSnap) begin
            r_yA     <= INIT_V;
            r_yB     <= INIT_V;
            r_update <= 1'b1;
          end else begin
            r_yA     <= w_clampA;
            r_yB     <= w_clampB;
            r_update <= (w_clampA != r_yA) || (w_clampB != r_yB);
          end
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign paddleA_y     = r_yA;
  assign paddleB_y     = r_yB;
  assign paddle_update = r_update;
  assign busy          = r_busy;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed self-checking bench for paddle_ctrl: hand-computed paddle positions
// across accumulation, saturation, clamping, enable, recentre and pipeline corner cases.
module tb_paddle_ctrl;

  logic       pixel_clk = 1'b0;
  logic       reset;
  logic       frame_tick, enable, center_req;
  logic       PlayerA_up_i, PlayerA_down_i, PlayerB_up_i, PlayerB_down_i;
  logic [9:0] paddleA_y, paddleB_y;
  logic       paddle_update, busy;

  int checks = 0;
  int errors = 0;
  int expA, expB;

  paddle_ctrl dut (
    .pixel_clk      (pixel_clk),
    .reset          (reset),
    .frame_tick     (frame_tick),
    .enable         (enable),
    .center_req     (center_req),
    .PlayerA_up_i   (PlayerA_up_i),
    .PlayerA_down_i (PlayerA_down_i),
    .PlayerB_up_i   (PlayerB_up_i),
    .PlayerB_down_i (PlayerB_down_i),
    .paddleA_y      (paddleA_y),
    .paddleB_y      (paddleB_y),
    .paddle_update  (paddle_update),
    .busy           (busy)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drives one cycle of inputs, sampled by the next edge, then returns 1ns after it.
  task automatic applyStimulus(input logic upA, input logic dnA, input logic upB,
                               input logic dnB, input logic tick, input logic cen);
    PlayerA_up_i   = upA;
    PlayerA_down_i = dnA;
    PlayerB_up_i   = upB;
    PlayerB_down_i = dnB;
    frame_tick     = tick;
    center_req     = cen;
    @(posedge pixel_clk);
    #1;
    PlayerA_up_i   = 1'b0;
    PlayerA_down_i = 1'b0;
    PlayerB_up_i   = 1'b0;
    PlayerB_down_i = 1'b0;
    frame_tick     = 1'b0;
    center_req     = 1'b0;
  endtask

  task automatic idleCycle();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic pulses(input int n, input logic upA, input logic dnA,
                        input logic upB, input logic dnB);
    for (int i = 0; i < n; i++) applyStimulus(upA, dnA, upB, dnB, 1'b0, 1'b0);
  endtask

  // Tick, then wait until the new positions are visible (two edges after the tick edge).
  task automatic runFrame();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("busy_in_snap", busy, 1);
    idleCycle();
    idleCycle();
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    frame_tick = 1'b0;
    center_req = 1'b0;
    PlayerA_up_i = 1'b0;
    PlayerA_down_i = 1'b0;
    PlayerB_up_i = 1'b0;
    PlayerB_down_i = 1'b0;
    repeat (2) @(posedge pixel_clk);
    #1;
    checkOutput("rst_yA", paddleA_y, 208);
    checkOutput("rst_yB", paddleB_y, 208);
    checkOutput("rst_update", paddle_update, 0);
    checkOutput("rst_busy", busy, 0);
    reset = 1'b0;

    // 3 A downs
    pulses(3, 1'b0, 1'b1, 1'b0, 1'b0);
    runFrame();
    checkOutput("t1_yA", paddleA_y, 232);
    checkOutput("t1_yB", paddleB_y, 208);
    checkOutput("t1_update", paddle_update, 1);
    idleCycle();
    checkOutput("t1_update_pulse", paddle_update, 0);
    checkOutput("t1_busy_done", busy, 0);

    // B up saturation and clamp at 0
    expB = 208;
    for (int f = 0; f < 4; f++) begin
      pulses(10, 1'b0, 1'b0, 1'b1, 1'b0);
      runFrame();
      expB = (expB >= 56) ? expB - 56 : 0;
      checkOutput("t2_yB", paddleB_y, expB);
      checkOutput("t2_update", paddle_update, 1);
    end
    pulses(10, 1'b0, 1'b0, 1'b1, 1'b0);
    runFrame();
    checkOutput("t2_yB_floor", paddleB_y, 0);
    checkOutput("t2_update_floor", paddle_update, 0);
    checkOutput("t2_yA_hold", paddleA_y, 232);

    // A to bottom clamp 416
    expA = 232;
    for (int f = 0; f < 4; f++) begin
      pulses(7, 1'b0, 1'b1, 1'b0, 1'b0);
      runFrame();
      expA = (expA + 56 > 416) ? 416 : expA + 56;
      checkOutput("t3_yA", paddleA_y, expA);
    end
    pulses(2, 1'b0, 1'b1, 1'b0, 1'b0);
    runFrame();
    checkOutput("t3_yA_ceiling", paddleA_y, 416);
    checkOutput("t3_update", paddle_update, 0);

    // up+down same cycle cancel
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    runFrame();
    checkOutput("t4_yA", paddleA_y, 416);
    checkOutput("t4_update", paddle_update, 0);

    // enable low drops presses
    enable = 1'b0;
    pulses(2, 1'b1, 1'b0, 1'b0, 1'b1);
    runFrame();
    checkOutput("t5_yA_disabled", paddleA_y, 416);
    checkOutput("t5_yB_disabled", paddleB_y, 0);
    checkOutput("t5_update_disabled", paddle_update, 0);
    enable = 1'b1;
    pulses(7, 1'b0, 1'b0, 1'b0, 1'b1);
    runFrame();
    pulses(7, 1'b0, 1'b0, 1'b0, 1'b1);
    runFrame();
    pulses(5, 1'b0, 1'b0, 1'b0, 1'b1);
    runFrame();
    checkOutput("t5_yB_152", paddleB_y, 152);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    runFrame();
    checkOutput("t5_center_yA", paddleA_y, 208);
    checkOutput("t5_center_yB", paddleB_y, 208);
    checkOutput("t5_center_update", paddle_update, 1);
    idleCycle();
    runFrame();
    checkOutput("t5_center_cleared", paddle_update, 0);

    // down pulse coincident with tick waits a frame
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idleCycle();
    idleCycle();
    checkOutput("t6_coinc_yA", paddleA_y, 208);
    checkOutput("t6_coinc_update", paddle_update, 0);
    runFrame();
    checkOutput("t6_next_yA", paddleA_y, 216);
    checkOutput("t6_next_update", paddle_update, 1);

    // tick while busy is ignored; its coincident pulse accumulates
    pulses(1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idleCycle();
    checkOutput("t6_busy_yA", paddleA_y, 224);
    checkOutput("t6_busy_update", paddle_update, 1);
    idleCycle();
    checkOutput("t6_busy_no_second", paddle_update, 0);
    checkOutput("t6_busy_idle", busy, 0);
    idleCycle();
    checkOutput("t6_busy_yA_hold", paddleA_y, 224);
    runFrame();
    checkOutput("t6_late_pulse_yA", paddleA_y, 232);

    // reset during SNAP aborts
    pulses(2, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    idleCycle();
    checkOutput("t6_rst_yA", paddleA_y, 208);
    checkOutput("t6_rst_yB", paddleB_y, 208);
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_update", paddle_update, 0);
    reset = 1'b0;
    runFrame();
    checkOutput("t6_post_rst_yA", paddleA_y, 208);
    checkOutput("t6_post_rst_update", paddle_update, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
